// File: rtl/wbram_layer_sequencer.sv
// rtl/wbram_layer_sequencer.sv - layer parameter store and two-slot weight-RAM fill/consume sequencer
module wbram_layer_sequencer #(
    parameter int MAX_OUT_CHANNEL = 128,
    parameter int MAX_IN_CHANNEL  = 45,
    parameter int MAX_KERNEL_SIZE = 5,
    parameter int MAX_NUM_LAYERS  = 4,
    parameter int PARAM_WIDTH     = $clog2(MAX_OUT_CHANNEL) + $clog2(MAX_IN_CHANNEL) +
                                    $clog2(MAX_KERNEL_SIZE) + $clog2(MAX_OUT_CHANNEL*MAX_KERNEL_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PARAM_WIDTH-1:0] cfg_data,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   wr_start,
    output logic [PARAM_WIDTH-1:0] wr_param,
    input  logic                   wr_done,
    output logic [PARAM_WIDTH-1:0] pe_param_data,
    output logic                   pe_param_valid,
    input  logic                   pe_param_ready,
    output logic [1:0]             pe_ptr_data,
    output logic                   pe_ptr_valid,
    input  logic                   pe_ptr_ready,
    input  logic                   rd_done,
    output logic                   busy,
    output logic                   done
);
    localparam int NL_W  = $clog2(MAX_NUM_LAYERS) + 1;
    localparam int IDX_W = (MAX_NUM_LAYERS > 1) ? $clog2(MAX_NUM_LAYERS) : 1;

    typedef enum logic [2:0] {IDLE, CFG_NL, CFG_LAYER, RUN, FIN} state_e;
    state_e state_q, state_d;

    logic [PARAM_WIDTH-1:0] regfile_q [MAX_NUM_LAYERS];
    logic [NL_W-1:0]        num_layers_q, cfg_idx_q, fill_idx_q, pe_idx_q;
    logic [1:0]             wr_ptr_q, rd_ptr_q, wr_ptr_inc;
    logic                   fill_out_q, layer_out_q, param_is_layer_q;
    logic                   wr_start_q, pe_param_valid_q, pe_ptr_valid_q, done_q;
    logic [PARAM_WIDTH-1:0] wr_param_q, pe_param_data_q;
    logic [1:0]             pe_ptr_data_q;

    logic            cfg_ready_c, busy_c, fin_c;
    logic            cfg_fire, start_fire, run_entry, fill_go, wr_adv, rd_adv;
    logic            param_fire, layer_load, full, empty;
    logic [NL_W-1:0] nl_raw, nl_clamped;

    assign cfg_fire   = cfg_valid && cfg_ready_c;
    assign start_fire = (state_q == IDLE) && start;
    assign nl_raw     = cfg_data[NL_W-1:0];
    assign nl_clamped = (nl_raw > NL_W'(MAX_NUM_LAYERS)) ? NL_W'(MAX_NUM_LAYERS) : nl_raw;
    // Two slots: bit0 selects the slot, bit1 distinguishes full from empty
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[0] == rd_ptr_q[0]) && (wr_ptr_q[1] != rd_ptr_q[1]);
    assign wr_ptr_inc = wr_ptr_q + 2'd1;
    assign run_entry  = (state_q == CFG_LAYER) && (state_d == RUN);
    assign fill_go    = (state_q == RUN) && !fill_out_q && !full && (fill_idx_q < num_layers_q);
    assign wr_adv     = wr_done && fill_out_q;
    assign rd_adv     = rd_done && layer_out_q;
    assign param_fire = pe_param_valid_q && pe_param_ready;
    assign layer_load = (state_q == RUN) && !empty && !layer_out_q && !pe_param_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = CFG_NL;
            CFG_NL:    if (cfg_fire) state_d = (nl_clamped == '0) ? FIN : CFG_LAYER;
            CFG_LAYER: if (cfg_fire && (cfg_idx_q == num_layers_q - NL_W'(1))) state_d = RUN;
            RUN:       if (pe_idx_q == num_layers_q) state_d = FIN;
            FIN:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready_c = (state_q == CFG_NL) || (state_q == CFG_LAYER);
        busy_c      = (state_q != IDLE);
        fin_c       = (state_q == FIN);
    end

    always_ff @(posedge clk) begin
        if ((state_q == CFG_LAYER) && cfg_fire) regfile_q[cfg_idx_q[IDX_W-1:0]] <= cfg_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_layers_q     <= '0;
            cfg_idx_q        <= '0;
            fill_idx_q       <= '0;
            pe_idx_q         <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fill_out_q       <= 1'b0;
            layer_out_q      <= 1'b0;
            param_is_layer_q <= 1'b0;
            wr_start_q       <= 1'b0;
            wr_param_q       <= '0;
            pe_param_valid_q <= 1'b0;
            pe_param_data_q  <= '0;
            pe_ptr_valid_q   <= 1'b0;
            pe_ptr_data_q    <= '0;
            done_q           <= 1'b0;
        end else if (start_fire) begin
            cfg_idx_q        <= '0;
            fill_idx_q       <= '0;
            pe_idx_q         <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fill_out_q       <= 1'b0;
            layer_out_q      <= 1'b0;
            param_is_layer_q <= 1'b0;
            wr_start_q       <= 1'b0;
            pe_param_valid_q <= 1'b0;
            pe_ptr_valid_q   <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            done_q <= fin_c;
            if ((state_q == CFG_NL) && cfg_fire)    num_layers_q <= nl_clamped;
            if ((state_q == CFG_LAYER) && cfg_fire) cfg_idx_q    <= cfg_idx_q + NL_W'(1);

            wr_start_q <= fill_go;
            if (fill_go) begin
                wr_param_q <= regfile_q[fill_idx_q[IDX_W-1:0]];
                fill_out_q <= 1'b1;
            end else if (wr_adv) begin
                wr_ptr_q   <= wr_ptr_inc;
                fill_idx_q <= fill_idx_q + NL_W'(1);
                fill_out_q <= 1'b0;
            end

            if (rd_adv) begin
                rd_ptr_q    <= rd_ptr_q + 2'd1;
                pe_idx_q    <= pe_idx_q + NL_W'(1);
                layer_out_q <= 1'b0;
            end

            // The first word of a run is the layer count; only later words occupy a slot
            if (run_entry) begin
                pe_param_valid_q <= 1'b1;
                pe_param_data_q  <= PARAM_WIDTH'(num_layers_q);
                param_is_layer_q <= 1'b0;
            end else if (layer_load) begin
                pe_param_valid_q <= 1'b1;
                pe_param_data_q  <= regfile_q[pe_idx_q[IDX_W-1:0]];
                param_is_layer_q <= 1'b1;
            end else if (param_fire) begin
                pe_param_valid_q <= 1'b0;
                if (param_is_layer_q) layer_out_q <= 1'b1;
            end

            if (wr_adv) begin
                pe_ptr_data_q  <= wr_ptr_inc;
                pe_ptr_valid_q <= 1'b1;
            end else if (pe_ptr_valid_q && pe_ptr_ready) begin
                pe_ptr_valid_q <= 1'b0;
            end
        end
    end

    assign cfg_ready      = cfg_ready_c;
    assign busy           = busy_c;
    assign done           = done_q;
    assign wr_start       = wr_start_q;
    assign wr_param       = wr_param_q;
    assign pe_param_valid = pe_param_valid_q;
    assign pe_param_data  = pe_param_data_q;
    assign pe_ptr_valid   = pe_ptr_valid_q;
    assign pe_ptr_data    = pe_ptr_data_q;
endmodule

// File: doc/wbram_layer_sequencer.md
WBRAM_LAYER_SEQUENCER -- requirements
Module: wbram_layer_sequencer

Interface
REQ-001 Parameters (name, default, meaning), SHALL be supported:
- MAX_OUT_CHANNEL, 128, output-channel limit
- MAX_IN_CHANNEL, 45, input-channel limit
- MAX_KERNEL_SIZE, 5, kernel-size limit
- MAX_NUM_LAYERS, 4, depth of the layer parameter store
- PARAM_WIDTH, sum of $clog2 of MAX_OUT_CHANNEL, MAX_IN_CHANNEL, MAX_KERNEL_SIZE and MAX_OUT_CHANNEL*MAX_KERNEL_SIZE (26 at defaults), layer parameter word width
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin one network run
- cfg_data  in  PARAM_WIDTH  configuration word
- cfg_valid  in  1  configuration word valid
- cfg_ready  out  1  configuration word accepted
- wr_start  out  1  one-cycle pulse: write controller fills the current slot
- wr_param  out  PARAM_WIDTH  layer word for that fill
- wr_done  in  1  one-cycle pulse: slot fill complete
- pe_param_data  out  PARAM_WIDTH  parameter word to the first PE
- pe_param_valid  out  1  parameter word valid
- pe_param_ready  in  1  parameter word accepted
- pe_ptr_data  out  2  write pointer to the first PE
- pe_ptr_valid  out  1  pointer valid
- pe_ptr_ready  in  1  pointer accepted
- rd_done  in  1  one-cycle pulse from the last PE: slot consumed
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run completion

Function
REQ-003 State machine SHALL have states IDLE, CFG_NL, CFG_LAYER, RUN and FIN.
REQ-004 IDLE->CFG_NL on start; start SHALL be ignored in every other state.
REQ-005 cfg_ready SHALL be high only in CFG_NL and CFG_LAYER; a word transfers when cfg_valid and cfg_ready are both high.
REQ-006 In CFG_NL the accepted word's low $clog2(MAX_NUM_LAYERS)+1 bits SHALL set num_layers, with values above MAX_NUM_LAYERS clamped to MAX_NUM_LAYERS.
REQ-007 After CFG_NL: num_layers==0 -> FIN; otherwise -> CFG_LAYER.
REQ-008 CFG_LAYER SHALL store each accepted word into regfile[cfg_idx], then increment cfg_idx; after word num_layers-1 -> RUN.
REQ-009 Pointers wr_ptr and rd_ptr SHALL be 2 bits each: bit0 is the slot, bit1 is the wrap bit; both reset to 0 on IDLE->CFG_NL.
- empty = (wr_ptr==rd_ptr)
- full = (bit0 equal) and (bit1 different)
- increment SHALL wrap 3->0.
REQ-010 Fill engine in RUN: when no fill is outstanding, not full and fill_idx<num_layers, assert wr_start for exactly one cycle with wr_param=regfile[fill_idx] and mark the fill outstanding.
REQ-011 wr_done while a fill is outstanding SHALL, on the next edge, increment wr_ptr and fill_idx and clear outstanding; wr_done with no fill outstanding SHALL be ignored.
REQ-012 Every wr_ptr update SHALL load pe_ptr_data with the new wr_ptr and set pe_ptr_valid; valid SHALL hold, with data stable, until the pe_ptr_ready handshake. A newer update while valid is pending SHALL overwrite the data and keep valid high.
REQ-013 Parameter channel, first word: on entry to RUN, send num_layers (zero-extended). pe_param_valid SHALL hold, with data stable, until pe_param_ready.
REQ-014 Parameter channel, per layer: send regfile[pe_idx] only when not empty, no layer is outstanding and no parameter word is pending; the handshake SHALL mark the layer outstanding.
REQ-015 rd_done while a layer is outstanding SHALL increment rd_ptr and pe_idx and clear outstanding; rd_done with no layer outstanding SHALL be ignored.
REQ-016 wr_done and rd_done in the same cycle SHALL both take effect; full/empty SHALL be evaluated from registered pointers only.
REQ-017 RUN->FIN when pe_idx reaches num_layers; FIN SHALL pulse done for one cycle, then -> IDLE.
REQ-018 Handshake-to-wr_start latency SHALL be 1 cycle minimum.

Reset
REQ-019 rst_n low SHALL asynchronously force:
- state IDLE
- all pointers, indices and outstanding flags 0
- outputs wr_start, pe_param_valid, pe_ptr_valid, cfg_ready, busy and done 0
- data outputs 0
REQ-020 rst_n asserted mid-RUN SHALL abandon the run; no further wr_start or done SHALL be issued until a new start.

Verification
REQ-021 start, num_layers=2, layer words A,B; immediate wr_done/rd_done -> wr_start carries A then B; pe params 2,A,B; pe_ptr 1,2; one done pulse.
REQ-022 num_layers=3, rd_done withheld -> exactly 2 wr_start pulses (full at wr_ptr=2, rd_ptr=0); third fill after the first rd_done.
REQ-023 wr_done and rd_done in the same cycle -> both pointers advance; no lost or duplicate fill.
REQ-024 num_layers word 0 -> done pulses 2 cycles after the config handshake; no wr_start. Word 7 -> clamped, 4 fills.
REQ-025 pe_param_ready and pe_ptr_ready held low 10 cycles -> data stable, valid held; run completes after release.
REQ-026 rst_n low during the second fill -> all outputs 0 immediately; a new start runs cleanly from pointer 0.
